// File: rtl/shift_sequencer.sv
// Multi-cycle SLL/SRL/SRA unit: one STEP-bit shift stage reused until the
// requested distance is consumed, with request/result valid-ready handshakes.
module shift_sequencer #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned STEP  = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] S,
   output logic             busy
);

   localparam int unsigned AMT_W = 5;

   localparam logic [1:0] OP_SLL  = 2'b00;
   localparam logic [1:0] OP_SRL  = 2'b01;
   localparam logic [1:0] OP_SRA  = 2'b10;
   localparam logic [1:0] OP_PASS = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      DONE  = 2'b10
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] value;
   logic [AMT_W-1:0] remaining;
   logic [1:0]       op_q;

   logic [AMT_W-1:0] step_k;
   logic [AMT_W-1:0] rem_next;
   logic [WIDTH-1:0] shifted;

   // Only the low five bits of B carry a shift distance.
   logic unused_b;
   assign unused_b = ^B[WIDTH-1:AMT_W];

   // One pass of the shared shift stage: distance is min(remaining, STEP).
   always_comb begin
      step_k   = (remaining < AMT_W'(STEP)) ? remaining : AMT_W'(STEP);
      rem_next = remaining - step_k;
      shifted  = value;
      case (op_q)
         OP_SLL:  shifted = value << step_k;
         OP_SRL:  shifted = value >> step_k;
         OP_SRA:  shifted = WIDTH'($signed(value) >>> step_k);
         default: shifted = value;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         value       <= '0;
         remaining   <= '0;
         op_q        <= OP_SLL;
         S           <= '0;
         res_valid   <= 1'b0;
         start_ready <= 1'b1;
         busy        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start_valid) begin
                  // Zero-distance and pass-through requests still spend one
                  // SHIFT cycle (k=0) so latency is never below one cycle.
                  state       <= SHIFT;
                  value       <= A;
                  op_q        <= op;
                  remaining   <= (op == OP_PASS) ? '0 : B[AMT_W-1:0];
                  start_ready <= 1'b0;
                  busy        <= 1'b1;
               end
            end
            SHIFT: begin
               value     <= shifted;
               remaining <= rem_next;
               if (rem_next == '0) begin
                  state     <= DONE;
                  S         <= shifted;
                  res_valid <= 1'b1;
               end
            end
            DONE: begin
               if (res_ready) begin
                  state       <= IDLE;
                  res_valid   <= 1'b0;
                  start_ready <= 1'b1;
                  busy        <= 1'b0;
               end
            end
            default: begin
               state       <= IDLE;
               res_valid   <= 1'b0;
               start_ready <= 1'b1;
               busy        <= 1'b0;
            end
         endcase
      end
   end

endmodule
